// File: rtl/pic_bus_pkg.sv
// Shared types and timing constants for the 8259 bus master.
package pic_bus_pkg;

    localparam int unsigned SETUP_CYCLES  = 1;
    localparam int unsigned STROBE_CYCLES = 2;
    localparam int unsigned HOLD_CYCLES   = 1;
    localparam int          CNT_W         = 4;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ICW1,
        S_ICW2,
        S_ICW3,
        S_ICW4,
        S_DONE
    } seq_e;

    // ICW3 only exists in cascade mode (SNGL=0); ICW4 only when IC4=1.
    function automatic seq_e next_icw(input seq_e s, input logic sngl, input logic ic4);
        case (s)
            S_ICW1:  next_icw = S_ICW2;
            S_ICW2:  next_icw = !sngl ? S_ICW3 : (ic4 ? S_ICW4 : S_DONE);
            S_ICW3:  next_icw = ic4 ? S_ICW4 : S_DONE;
            default: next_icw = S_DONE;
        endcase
    endfunction

endpackage

// File: rtl/pic_bus_cycle.sv
// Phase engine: runs one SETUP/STROBE/HOLD bus access per start pulse.
module pic_bus_cycle import pic_bus_pkg::*; (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       write,
    input  logic       a0,
    input  logic [7:0] wdata,
    input  logic [7:0] data_in,
    output phase_e     phase,
    output logic       hold_end,
    output logic       done,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       A0,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       rsp_valid,
    output logic [7:0] rsp_data
);

    logic [CNT_W-1:0] cnt_q;
    logic             wr_q;

    assign hold_end = (phase == PH_HOLD) && (cnt_q == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            phase     <= PH_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            done      <= 1'b0;
            CS_n      <= 1'b1;
            RD_n      <= 1'b1;
            WR_n      <= 1'b1;
            A0        <= 1'b0;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            done <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        phase    <= PH_SETUP;
                        cnt_q    <= CNT_W'(SETUP_CYCLES - 1);
                        wr_q     <= write;
                        CS_n     <= 1'b0;
                        A0       <= a0;
                        data_out <= write ? wdata : 8'h00;
                        data_oe  <= write;
                    end
                end
                PH_SETUP: begin
                    if (cnt_q == '0) begin
                        phase <= PH_STROBE;
                        cnt_q <= CNT_W'(STROBE_CYCLES - 1);
                        WR_n  <= ~wr_q;
                        RD_n  <= wr_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                PH_STROBE: begin
                    if (cnt_q == '0) begin
                        phase <= PH_HOLD;
                        cnt_q <= CNT_W'(HOLD_CYCLES - 1);
                        WR_n  <= 1'b1;
                        RD_n  <= 1'b1;
                        // read data is captured on the edge that ends the strobe
                        if (!wr_q) begin
                            rsp_data  <= data_in;
                            rsp_valid <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        phase     <= PH_IDLE;
                        CS_n      <= 1'b1;
                        data_oe   <= 1'b0;
                        rsp_valid <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pic_bus_master.sv
// 8259 bus master: ICW init sequencer plus a single-access request channel.
module pic_bus_master import pic_bus_pkg::*; (
    input  logic       clock,
    input  logic       reset,
    input  logic       init_start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    output logic       init_busy,
    output logic       init_done,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_a0,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       A0,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in
);

    seq_e       seq_q;
    logic       run_q;
    logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q;

    phase_e     phase;
    logic       hold_end;
    logic       cyc_done;
    logic       cyc_idle;
    logic       accept_init;
    logic       accept_req;
    logic       icw_issue;
    logic       cyc_start;
    logic       cyc_write;
    logic       cyc_a0;
    logic [7:0] cyc_wdata;
    logic [7:0] icw_byte;

    assign cyc_idle    = (phase == PH_IDLE);
    assign init_busy   = seq_q inside {S_ICW1, S_ICW2, S_ICW3, S_ICW4};
    assign init_done   = cyc_done && (seq_q == S_DONE);
    // run_q keeps the channel closed for the first cycle out of reset
    assign accept_init = init_start && run_q && cyc_idle && !init_busy;
    assign req_ready   = run_q && cyc_idle && !init_busy && !init_start;
    assign accept_req  = req_valid && req_ready;
    assign icw_issue   = init_busy && cyc_idle;

    always_comb begin
        icw_byte = 8'h00;
        unique case (seq_q)
            S_ICW1:  icw_byte = icw1_q;
            S_ICW2:  icw_byte = icw2_q;
            S_ICW3:  icw_byte = icw3_q;
            S_ICW4:  icw_byte = icw4_q;
            default: icw_byte = 8'h00;
        endcase
    end

    assign cyc_start = accept_req || icw_issue;
    assign cyc_write = icw_issue ? 1'b1 : req_write;
    assign cyc_a0    = icw_issue ? (seq_q != S_ICW1) : req_a0;
    assign cyc_wdata = icw_issue ? icw_byte : req_wdata;

    always_ff @(posedge clock) begin
        if (!reset) begin
            seq_q  <= S_IDLE;
            run_q  <= 1'b0;
            icw1_q <= 8'h00;
            icw2_q <= 8'h00;
            icw3_q <= 8'h00;
            icw4_q <= 8'h00;
        end else begin
            run_q <= 1'b1;
            if (accept_init) begin
                seq_q  <= S_ICW1;
                icw1_q <= icw1;
                icw2_q <= icw2;
                icw3_q <= icw3;
                icw4_q <= icw4;
            end else if (seq_q == S_DONE) begin
                seq_q <= S_IDLE;
            end else if (init_busy && hold_end) begin
                seq_q <= next_icw(seq_q, icw1_q[1], icw1_q[0]);
            end
        end
    end

    pic_bus_cycle u_cycle (
        .clock     (clock),
        .reset     (reset),
        .start     (cyc_start),
        .write     (cyc_write),
        .a0        (cyc_a0),
        .wdata     (cyc_wdata),
        .data_in   (data_in),
        .phase     (phase),
        .hold_end  (hold_end),
        .done      (cyc_done),
        .CS_n      (CS_n),
        .RD_n      (RD_n),
        .WR_n      (WR_n),
        .A0        (A0),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

endmodule

// File: tb/tb_pic_bus_master.sv
// Directed bench for pic_bus_master: access timing, ICW sequences, reset abort.
module tb_pic_bus_master;

    logic       clock = 1'b0;
    logic       reset;
    logic       init_start;
    logic [7:0] icw1, icw2, icw3, icw4;
    logic       init_busy, init_done;
    logic       req_valid, req_ready, req_write, req_a0;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       CS_n, RD_n, WR_n, A0, data_oe;
    logic [7:0] data_out, data_in;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    pic_bus_master dut (
        .clock      (clock),
        .reset      (reset),
        .init_start (init_start),
        .icw1       (icw1),
        .icw2       (icw2),
        .icw3       (icw3),
        .icw4       (icw4),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_a0     (req_a0),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .CS_n       (CS_n),
        .RD_n       (RD_n),
        .WR_n       (WR_n),
        .A0         (A0),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .data_in    (data_in)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // advance to the falling edge of the next cycle
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // bus monitor: logs write strobes and checks invariants every cycle
    logic [8:0] wlog[$];
    int         wcyc[$];
    int         cyc       = 0;
    int         done_cnt  = 0;
    int         done_cyc  = 0;
    logic       wr_prev   = 1'b1;
    logic       busy_seen = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (!WR_n && wr_prev) begin
            wlog.push_back({A0, data_out});
            wcyc.push_back(cyc);
        end
        wr_prev = WR_n;
        if (init_busy) busy_seen = 1'b1;
        if (init_done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", {31'b0, init_busy}, 0);
            chk("ready_at_done", {31'b0, req_ready}, 1);
        end
        chk("rd_wr_overlap", {31'b0, ~RD_n & ~WR_n}, 0);
        chk("oe_during_read", {31'b0, ~RD_n & data_oe}, 0);
    end

    typedef struct {
        logic       wr;
        logic       a0;
        logic [7:0] wdata;
        logic [7:0] din;
        logic       exp_rsp;
        logic [7:0] exp_data;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];
    vec_t v;

    // exp holds up to four {A0,data} entries, first write in the top bits
    task automatic run_init(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3,
                            input logic [7:0] c4, input int n_exp, input logic [35:0] exp);
        wlog.delete();
        wcyc.delete();
        done_cnt   = 0;
        icw1       = c1;
        icw2       = c2;
        icw3       = c3;
        icw4       = c4;
        init_start = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_a0     = 1'b1;
        req_wdata  = 8'hEE;
        #1;
        chk($sformatf("init%02h_beats_req", c1), {31'b0, req_ready}, 0);
        step();
        init_start = 1'b0;
        req_valid  = 1'b0;
        chk($sformatf("init%02h_busy", c1), {31'b0, init_busy}, 1);
        for (int k = 0; k < 60 && done_cnt == 0; k++) step();
        repeat (3) step();
        chk($sformatf("init%02h_done_cnt", c1), done_cnt, 1);
        chk($sformatf("init%02h_nwrites", c1), wlog.size(), n_exp);
        for (int i = 0; i < n_exp && i < wlog.size(); i++)
            chk($sformatf("init%02h_w%0d", c1, i), {23'b0, wlog[i]}, {23'b0, exp[35-9*i -: 9]});
        for (int i = 1; i < wcyc.size(); i++)
            chk($sformatf("init%02h_gap%0d", c1, i), wcyc[i] - wcyc[i-1], 5);
        if (wcyc.size() > 0)
            chk($sformatf("init%02h_done_lat", c1), done_cyc - wcyc[$], 3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{wr: 1'b0, a0: 1'b0, wdata: 8'h00, din: 8'hA5, exp_rsp: 1'b1, exp_data: 8'hA5};
        vecs[1] = '{wr: 1'b1, a0: 1'b1, wdata: 8'h3C, din: 8'h11, exp_rsp: 1'b0, exp_data: 8'h00};
        vecs[2] = '{wr: 1'b1, a0: 1'b1, wdata: 8'h5A, din: 8'h22, exp_rsp: 1'b0, exp_data: 8'h00};
        vecs[3] = '{wr: 1'b0, a0: 1'b1, wdata: 8'hFF, din: 8'h3C, exp_rsp: 1'b1, exp_data: 8'h3C};
        vecs[4] = '{wr: 1'b1, a0: 1'b0, wdata: 8'hFF, din: 8'h00, exp_rsp: 1'b0, exp_data: 8'h00};
        vecs[5] = '{wr: 1'b0, a0: 1'b0, wdata: 8'h77, din: 8'h00, exp_rsp: 1'b1, exp_data: 8'h00};

        reset      = 1'b0;
        init_start = 1'b0;
        icw1       = 8'h00;
        icw2       = 8'h00;
        icw3       = 8'h00;
        icw4       = 8'h00;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_a0     = 1'b0;
        req_wdata  = 8'h00;
        data_in    = 8'h00;

        repeat (3) @(negedge clock);
        chk("rst_strobes", {29'b0, CS_n, RD_n, WR_n}, 32'h7);
        chk("rst_a0_oe", {30'b0, A0, data_oe}, 0);
        chk("rst_data_out", {24'b0, data_out}, 0);
        chk("rst_ready", {31'b0, req_ready}, 0);
        chk("rst_rsp", {23'b0, rsp_valid, rsp_data}, 0);
        chk("rst_init", {30'b0, init_busy, init_done}, 0);
        reset = 1'b1;
        step();
        chk("ready_after_rst", {31'b0, req_ready}, 1);

        // single accesses, back to back: each accepted in the N+5 cycle of the previous one
        for (int i = 0; i < NV; i++) begin
            v         = vecs[i];
            req_valid = 1'b1;
            req_write = v.wr;
            req_a0    = v.a0;
            req_wdata = v.wdata;
            data_in   = v.din;
            #1;
            chk($sformatf("v%0d_ready", i), {31'b0, req_ready}, 1);
            step();
            req_valid = 1'b0;
            req_wdata = 8'h00;
            chk($sformatf("v%0d_setup", i), {28'b0, CS_n, RD_n, WR_n, data_oe},
                {28'b0, 1'b0, 1'b1, 1'b1, v.wr});
            chk($sformatf("v%0d_setup_a0", i), {31'b0, A0}, {31'b0, v.a0});
            chk($sformatf("v%0d_ready_busy", i), {31'b0, req_ready}, 0);
            if (v.wr) chk($sformatf("v%0d_setup_data", i), {24'b0, data_out}, {24'b0, v.wdata});
            for (int s = 0; s < 2; s++) begin
                step();
                chk($sformatf("v%0d_strobe%0d", i, s), {28'b0, CS_n, RD_n, WR_n, data_oe},
                    {28'b0, 1'b0, v.wr, ~v.wr, v.wr});
                chk($sformatf("v%0d_strobe%0d_a0", i, s), {31'b0, A0}, {31'b0, v.a0});
            end
            step();
            chk($sformatf("v%0d_hold", i), {28'b0, CS_n, RD_n, WR_n, data_oe},
                {28'b0, 1'b0, 1'b1, 1'b1, v.wr});
            chk($sformatf("v%0d_hold_rsp", i), {31'b0, rsp_valid}, {31'b0, v.exp_rsp});
            if (v.exp_rsp) chk($sformatf("v%0d_rsp_data", i), {24'b0, rsp_data}, {24'b0, v.exp_data});
            if (v.wr) chk($sformatf("v%0d_hold_data", i), {24'b0, data_out}, {24'b0, v.wdata});
            step();
            chk($sformatf("v%0d_idle", i), {28'b0, CS_n, RD_n, WR_n, data_oe}, 32'he);
            chk($sformatf("v%0d_idle_rsp", i), {31'b0, rsp_valid}, 0);
            chk($sformatf("v%0d_idle_ready", i), {31'b0, req_ready}, 1);
        end

        // reset during the strobe of a read aborts it without a response
        req_valid = 1'b1;
        req_write = 1'b0;
        req_a0    = 1'b0;
        data_in   = 8'h99;
        step();
        req_valid = 1'b0;
        step();
        chk("abort_in_strobe", {31'b0, RD_n}, 0);
        reset = 1'b0;
        step();
        chk("abort_strobes", {29'b0, CS_n, RD_n, WR_n}, 32'h7);
        chk("abort_rsp", {31'b0, rsp_valid}, 0);
        chk("abort_ready_in_rst", {31'b0, req_ready}, 0);
        reset = 1'b1;
        step();
        chk("abort_ready_after", {31'b0, req_ready}, 1);
        chk("abort_no_rsp", {31'b0, rsp_valid}, 0);

        // init_start while a request access is in flight is dropped
        wlog.delete();
        wcyc.delete();
        busy_seen = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_a0    = 1'b0;
        req_wdata = 8'h42;
        step();
        req_valid = 1'b0;
        step();
        icw1       = 8'h11;
        icw2       = 8'h20;
        icw3       = 8'h04;
        icw4       = 8'h01;
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        repeat (10) step();
        chk("ign_busy_seen", {31'b0, busy_seen}, 0);
        chk("ign_nwrites", wlog.size(), 1);
        if (wlog.size() > 0) chk("ign_write", {23'b0, wlog[0]}, {23'b0, 9'h042});

        // ICW sequences: full, single (no ICW3/4), single with ICW4, cascade without ICW4
        run_init(8'h11, 8'h20, 8'h04, 8'h01, 4, {9'h011, 9'h120, 9'h104, 9'h101});
        run_init(8'h12, 8'h34, 8'h56, 8'h78, 2, {9'h012, 9'h134, 9'h000, 9'h000});
        run_init(8'h13, 8'h34, 8'h56, 8'h78, 3, {9'h013, 9'h134, 9'h178, 9'h000});
        run_init(8'h10, 8'h34, 8'h56, 8'h78, 3, {9'h010, 9'h134, 9'h156, 9'h000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
